// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx_core among NUM_REQ producers
// Optional tag byte before each payload: UART_TX_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       arb_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       timeout_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state, state_d;
  logic [OW-1:0]       rr_ptr, rr_ptr_d, owner_d, owner_inc;
  logic [OW-1:0]       g, g_hi, g_any;
  logic                found_hi, found_any;
  logic [DATA_W-1:0]   g_data, tx_data_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic                tx_start_d, timeout_d;
  logic [CW-1:0]       cnt, cnt_d;
`ifdef UART_TX_ARB_TAG_EN
  logic [DATA_W-1:0]   payload, payload_d;
  logic                phase, phase_d;
`endif

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    g_hi      = '0;
    g_any     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_any = 1'b1;
        g_any     = OW'(i);
        if (OW'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          g_hi     = OW'(i);
        end
      end
    end
    g      = found_hi ? g_hi : g_any;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OW'(i) == g) g_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    tx_data_d  = tx_data;
    ack_d      = '0;
    tx_start_d = tx_start;
    timeout_d  = 1'b0;
    cnt_d      = cnt;
`ifdef UART_TX_ARB_TAG_EN
    payload_d  = payload;
    phase_d    = phase;
`endif
    case (state)
      IDLE: begin
        if (found_any) begin
          owner_d   = g;
          ack_d     = NUM_REQ'(1) << g;
`ifdef UART_TX_ARB_TAG_EN
          tx_data_d = DATA_W'(g);
          payload_d = g_data;
          phase_d   = 1'b0;
`else
          tx_data_d = g_data;
`endif
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_d = ~tx_start;
        cnt_d      = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          rr_ptr_d  = owner_inc;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_ARB_TAG_EN
          if (!phase) begin
            tx_data_d = payload;
            phase_d   = 1'b1;
            state_d   = LAUNCH;
          end else begin
            rr_ptr_d = owner_inc;
            state_d  = IDLE;
          end
`else
          rr_ptr_d = owner_inc;
          state_d  = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      tx_data     <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      arb_busy    <= 1'b0;
      cnt         <= '0;
`ifdef UART_TX_ARB_TAG_EN
      payload     <= '0;
      phase       <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      owner       <= owner_d;
      tx_data     <= tx_data_d;
      ack         <= ack_d;
      tx_start    <= tx_start_d;
      timeout_err <= timeout_d;
      arb_busy    <= (state_d != IDLE);
      cnt         <= cnt_d;
`ifdef UART_TX_ARB_TAG_EN
      payload     <= payload_d;
      phase       <= phase_d;
`endif
    end
  end

endmodule
